// File: rtl/mem_responder.sv
// Word-addressed SRAM responder for a req/gnt/rvalid data port: byte-enable
// writes, programmable grant and response latency, and out-of-range errors.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
   parameter int unsigned GNT_LATENCY    = 0,
   parameter int unsigned RVALID_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 16;
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GNT_WAIT,
      S_BUSY,
      S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               gnt;
   logic               enter_resp;

   logic [31:0]        lat_addr_q;
   logic               lat_we_q;
   logic [3:0]         lat_be_q;
   logic [31:0]        lat_wdata_q;

   logic               rvalid_q;
   logic [31:0]        rdata_q;
   logic               err_q;

   logic [31:0]        eff_addr;
   logic               eff_we;
   logic [3:0]         eff_be;
   logic [31:0]        eff_wdata;
   logic               in_range;
   logic [IDX_W-1:0]   idx;

   logic [31:0]        mem [DEPTH_WORDS];

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (GNT_LATENCY == 0) begin
                  gnt = 1'b1;
               end else begin
                  state_d = S_GNT_WAIT;
                  cnt_d   = CNT_W'(GNT_LATENCY - 1);
               end
            end
         end
         S_GNT_WAIT: begin
            if (!req_i)                  state_d = S_IDLE;
            else if (cnt_q == '0)        gnt     = 1'b1;
            else                         cnt_d   = cnt_q - 1'b1;
         end
         S_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // With a one-cycle response the gnt edge itself is the edge into Resp.
      if (gnt) begin
         if (RVALID_LATENCY <= 1) begin
            state_d = S_RESP;
            cnt_d   = '0;
         end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(RVALID_LATENCY - 1);
         end
      end
   end

   assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

   // On the gnt cycle the live inputs are used, afterwards the latched copy.
   assign eff_addr  = (state_q == S_BUSY) ? lat_addr_q  : addr_i;
   assign eff_we    = (state_q == S_BUSY) ? lat_we_q    : we_i;
   assign eff_be    = (state_q == S_BUSY) ? lat_be_q    : be_i;
   assign eff_wdata = (state_q == S_BUSY) ? lat_wdata_q : wdata_i;

   assign in_range = (eff_addr >= BASE_ADDR) && ({1'b0, eff_addr} < END_ADDR);
   assign idx      = IDX_W'((eff_addr - BASE_ADDR) >> 2);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_addr_q  <= '0;
         lat_we_q    <= 1'b0;
         lat_be_q    <= '0;
         lat_wdata_q <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= enter_resp;
         if (gnt) begin
            lat_addr_q  <= addr_i;
            lat_we_q    <= we_i;
            lat_be_q    <= be_i;
            lat_wdata_q <= wdata_i;
         end
         if (enter_resp) begin
            rdata_q <= (in_range && !eff_we) ? mem[idx] : '0;
            err_q   <= !in_range;
         end else begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   // NOTE: the array has no reset; a reset mid-transaction never reaches the
   // commit edge, so pending writes are dropped and stored words survive.
   always_ff @(posedge clk) begin
      if (enter_resp && eff_we && in_range) begin
         for (int k = 0; k < 4; k++) begin
            if (eff_be[k]) mem[idx][8*k +: 8] <= eff_wdata[8*k +: 8];
         end
      end
   end

   assign gnt_o    = gnt && rst_n;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover default latency,
// GNT=2/RVALID=3, and GNT=3 abort behaviour.
module tb_mem_responder;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [2:0]  err;
   logic [31:0] rdata [3];

   int n_cmp = 0;
   int n_bad = 0;

   mem_responder dut0 (
      .clk(clk), .rst_n(rst_n), .req_i(req[0]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0])
   );

   mem_responder #(.GNT_LATENCY(2), .RVALID_LATENCY(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_i(req[1]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1])
   );

   mem_responder #(.GNT_LATENCY(3), .RVALID_LATENCY(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_i(req[2]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one transaction starting at posedge+1; cycle 0 is the first cycle
   // req is seen. Returns gnt cycle and rvalid cycle (-1 if never seen).
   task automatic txn(input int inst, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d, input bit hold,
                      output int gc, output int rc, output logic [31:0] rd,
                      output logic e);
      int c;
      c  = 0;
      gc = -1;
      rc = -1;
      rd = 'x;
      e  = 1'bx;
      addr = a; we = w; be = b; wdata = d;
      req[inst] = 1'b1;
      while (c < 40 && rc < 0) begin
         @(negedge clk);
         if (gnt[inst] && gc < 0) gc = c;
         if (rvalid[inst]) begin
            rc = c;
            rd = rdata[inst];
            e  = err[inst];
         end
         @(posedge clk);
         #1;
         if (gc >= 0 && !hold) req[inst] = 1'b0;
         c++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({gnt, rvalid, err} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 0", {gnt, rvalid, err});
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rdata[i] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata%0d: got %h want 0", i, rdata[i]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_defaults();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      txn(0, 32'h0010_0004, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 0 || rc !== 1) begin
         n_bad++;
         $display("FAIL def_wr_timing: got gnt@%0d rvalid@%0d want 0/1", gc, rc);
      end
      n_cmp++;
      if (e !== 1'b0 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL def_wr_resp: got err=%b rdata=%h want 0/0", e, rd);
      end
      txn(0, 32'h0010_0004, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 0 || rc - gc !== 1) begin
         n_bad++;
         $display("FAIL def_rd_timing: got gnt@%0d rvalid@%0d want 0/1", gc, rc);
      end
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
         n_bad++;
         $display("FAIL def_rd_data: got %h err=%b want deadbeef err=0", rd, e);
      end
   endtask

   task automatic test_byte_enables();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      txn(0, 32'h0010_0008, 1'b1, 4'b1111, 32'h1122_3344, 1'b0, gc, rc, rd, e);
      txn(0, 32'h0010_0008, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b0, gc, rc, rd, e);
      txn(0, 32'h0010_0008, 1'b0, 4'b0000, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'h11BB_33DD) begin
         n_bad++;
         $display("FAIL be_merge: got %h want 11bb33dd", rd);
      end
      txn(0, 32'h0010_0008, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rc !== 1 || e !== 1'b0) begin
         n_bad++;
         $display("FAIL be_zero_resp: got rvalid@%0d err=%b want 1/0", rc, e);
      end
      txn(0, 32'h0010_0008, 1'b0, 4'b0000, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'h11BB_33DD) begin
         n_bad++;
         $display("FAIL be_zero_keep: got %h want 11bb33dd", rd);
      end
   endtask

   task automatic test_latency();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      txn(1, 32'h0010_0010, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 2 || rc - gc !== 3) begin
         n_bad++;
         $display("FAIL lat_wr_timing: got gnt@%0d rvalid@%0d want 2/5", gc, rc);
      end
      txn(1, 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 2 || rc !== 5 || rd !== 32'hCAFE_F00D) begin
         n_bad++;
         $display("FAIL lat_rd: got gnt@%0d rvalid@%0d data=%h want 2/5/cafef00d",
                  gc, rc, rd);
      end
   endtask

   task automatic test_back_to_back();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      txn(0, 32'h0010_0004, 1'b0, 4'h0, 32'h0, 1'b1, gc, rc, rd, e);
      txn(0, 32'h0010_0008, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 0 || rc !== 1 || rd !== 32'h11BB_33DD) begin
         n_bad++;
         $display("FAIL b2b_def: got gnt@%0d rvalid@%0d data=%h want 0/1/11bb33dd",
                  gc, rc, rd);
      end
      txn(1, 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b1, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 2 || rc !== 5) begin
         n_bad++;
         $display("FAIL b2b_lat_first: got gnt@%0d rvalid@%0d want 2/5", gc, rc);
      end
      txn(1, 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 2 || rc !== 5 || rd !== 32'hCAFE_F00D) begin
         n_bad++;
         $display("FAIL b2b_lat_second: got gnt@%0d rvalid@%0d data=%h want 2/5/cafef00d",
                  gc, rc, rd);
      end
   endtask

   task automatic test_range();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      txn(0, 32'h0010_0000, 1'b1, 4'hF, 32'h1234_5678, 1'b0, gc, rc, rd, e);
      txn(0, 32'h000F_FFFC, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (e !== 1'b1 || rd !== 32'h0 || rc !== 1) begin
         n_bad++;
         $display("FAIL rng_below: got err=%b data=%h rvalid@%0d want 1/0/1", e, rd, rc);
      end
      txn(0, 32'h0010_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (e !== 1'b1 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL rng_above_wr: got err=%b data=%h want 1/0", e, rd);
      end
      txn(0, 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (e !== 1'b1) begin
         n_bad++;
         $display("FAIL rng_top_of_space: got err=%b want 1", e);
      end
      txn(0, 32'h0010_0000, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'h1234_5678 || e !== 1'b0) begin
         n_bad++;
         $display("FAIL rng_word0_kept: got %h err=%b want 12345678 err=0", rd, e);
      end
      txn(0, 32'h0010_0004, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL rng_word1_kept: got %h want deadbeef", rd);
      end
      txn(0, 32'h0010_0008, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'h11BB_33DD) begin
         n_bad++;
         $display("FAIL rng_word2_kept: got %h want 11bb33dd", rd);
      end
      txn(0, 32'h0010_0FFC, 1'b1, 4'hF, 32'h600D_F00D, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (e !== 1'b0) begin
         n_bad++;
         $display("FAIL rng_last_wr: got err=%b want 0", e);
      end
      txn(0, 32'h0010_0FFC, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'h600D_F00D || e !== 1'b0) begin
         n_bad++;
         $display("FAIL rng_last_rd: got %h err=%b want 600df00d err=0", rd, e);
      end
   endtask

   task automatic test_abort();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      logic saw_gnt;
      addr = 32'h0010_0020; we = 1'b0; be = 4'h0; wdata = 32'h0;
      req[2] = 1'b1;
      @(negedge clk);
      saw_gnt = gnt[2];
      @(posedge clk);
      #1;
      req[2] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         saw_gnt = saw_gnt | gnt[2];
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (saw_gnt !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_no_gnt: got gnt seen=%b want 0", saw_gnt);
      end
      txn(2, 32'h0010_0020, 1'b1, 4'hF, 32'h0F0F_0F0F, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (gc !== 3 || rc !== 4) begin
         n_bad++;
         $display("FAIL abort_regrant: got gnt@%0d rvalid@%0d want 3/4", gc, rc);
      end
      txn(2, 32'h0010_0020, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'h0F0F_0F0F) begin
         n_bad++;
         $display("FAIL abort_readback: got %h want 0f0f0f0f", rd);
      end
   endtask

   task automatic test_reset_mid();
      int gc, rc;
      logic [31:0] rd;
      logic e;
      logic got;
      logic saw_rv;
      addr = 32'h0010_0010; we = 1'b1; be = 4'hF; wdata = 32'h0BAD_BEEF;
      req[1] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = gnt[1];
         @(posedge clk);
         #1;
      end
      req[1] = 1'b0;
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_gnt: got %b want 1", got);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({gnt[1], rvalid[1], err[1]} !== 3'b0 || rdata[1] !== 32'h0) begin
         n_bad++;
         $display("FAIL rstmid_outs: got gnt/rv/err=%b rdata=%h want 0",
                  {gnt[1], rvalid[1], err[1]}, rdata[1]);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      saw_rv = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw_rv = saw_rv | rvalid[1];
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (saw_rv !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_no_rvalid: got %b want 0", saw_rv);
      end
      txn(1, 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b0, gc, rc, rd, e);
      n_cmp++;
      if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_word_kept: got %h err=%b want cafef00d err=0", rd, e);
      end
   endtask

   initial begin
      req = 3'b000; addr = '0; we = 1'b0; be = '0; wdata = '0;
      test_reset();
      test_defaults();
      test_byte_enables();
      test_latency();
      test_back_to_back();
      test_range();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the PULPino-style req/gnt/rvalid data interface: it is the slave that a cache or core master issues requests to.
- Word-addressed SRAM model with byte-enable writes, programmable grant and response latency, and an address-range error.
- One outstanding transaction at a time.
- Sits behind the cache's memory port in simulation and on the CW305 fabric as the backing data store.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two.
- BASE_ADDR, 32'h0010_0000, byte address of word 0; aligned to 4*DEPTH_WORDS.
- GNT_LATENCY, 0, idle cycles with req high before gnt is asserted (0 = gnt in the first cycle req is seen).
- RVALID_LATENCY, 1, cycles from the gnt cycle to the rvalid cycle; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  1  master request.
- addr_i  input  32  byte address; bits [1:0] ignored.
- we_i  input  1  1 = write, 0 = read.
- be_i  input  4  byte enables for writes; be_i[k] covers wdata_i[8k+7:8k].
- wdata_i  input  32  write data.
- gnt_o  output  1  request accepted; combinational from state and req_i.
- rvalid_o  output  1  response valid; registered.
- rdata_o  output  32  read data; registered; valid only while rvalid_o=1.
- err_o  output  1  response carries an error; registered; valid only while rvalid_o=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=Idle, latency counter=0.
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
  - All latched request fields cleared.
  - Memory array is not reset; its contents are undefined until written.
- Idle state:
  - If req_i=1 and GNT_LATENCY=0: gnt_o=1 this cycle and the request is captured; go to Busy.
  - If req_i=1 and GNT_LATENCY>0: load counter=GNT_LATENCY-1 and go to GntWait.
- GntWait state:
  - Counter decrements each cycle while req_i=1.
  - When the counter is 0 and req_i=1: gnt_o=1, request captured, go to Busy.
  - req_i dropping before gnt (protocol violation): return to Idle; no grant is issued.
- Capture (on the gnt cycle):
  - Latch addr_i, we_i, be_i, wdata_i.
  - Load counter=RVALID_LATENCY-1.
- Busy state:
  - gnt_o=0 regardless of req_i.
  - Counter decrements each cycle.
  - When the counter is 0, go to Resp; the registered outputs take effect that edge.
- Resp state (rvalid_o=1 for exactly one cycle):
  - In-range read: rdata_o=mem[index], err_o=0.
  - In-range write: bytes with be=1 updated at the transition into Resp; bytes with be=0 unchanged; rdata_o=0, err_o=0.
  - Write with be=4'b0000: no memory change, normal response.
  - Out-of-range address: no memory change, rdata_o=0, err_o=1.
  - Next cycle: return to Idle. The earliest next gnt is the cycle after rvalid_o, even if req_i was held high throughout.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2, width log2(DEPTH_WORDS).
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, compared in 32 bits without wrap-around; the top word is in range.
- Read-after-write to the same word in back-to-back transactions returns the new data.
- Reset asserted mid-transaction:
  - Immediate return to Idle; no rvalid is ever produced.
  - Any write not yet committed is dropped.
  - Words already written keep their contents.
- Request inputs are ignored outside Idle, GntWait and the gnt cycle.

Test Plan:
- Defaults: write addr 0x0010_0004, wdata 0xDEADBEEF, be 4'b1111 → gnt in the same cycle as req, rvalid 1 cycle later, err=0. Then read the same address → rdata_o=0xDEADBEEF exactly RVALID_LATENCY cycles after gnt.
- Byte enables: write 0x11223344 with be 4'b1111, then write 0xAABBCCDD with be 4'b0101 → read returns 0x11BB33DD.
- Latency sweep GNT_LATENCY=2, RVALID_LATENCY=3, req held high → gnt on the 3rd cycle of req, rvalid 3 cycles after gnt. Back-to-back requests → second gnt no earlier than the cycle after the first rvalid.
- Range edges: read 0x000F_FFFC → err_o=1, rdata_o=0. Write 0x0010_1000 (DEPTH=1024) → err_o=1 and memory unchanged (verified by reading all previously written words). 0x0010_0FFC → err_o=0.
- Abort cases:
  - GNT_LATENCY=3, req dropped after 1 cycle → no gnt, state returns to Idle, a new req is later granted after the full 3-cycle wait.
  - rst_n pulsed low in Busy during a write → no rvalid, target word retains its old value, outputs are all 0 during reset.
